// File: rtl/sin_gen_nco.sv
`default_nettype none
// ============================================================================
//  Module   : sin_gen_nco
//  Purpose  : Numerically controlled sine oscillator. A phase accumulator
//             with run-time tuning word feeds a quarter-wave LUT (symmetry
//             folded) followed by amplitude scaling. One signed sample is
//             produced per clk_en strobe, three clocks later.
//  Ports    : clk        - system clock
//             rst        - asynchronous reset, active low
//             clk_en     - sample strobe
//             cfg_valid  - configuration word valid
//             cfg_ready  - configuration can be accepted
//             cfg_sync   - 1: apply at next accumulator wrap, 0: immediately
//             cfg_freq   - frequency tuning word
//             cfg_phase  - phase offset
//             cfg_amp    - unsigned amplitude (unity = 2^(AMP_W-1))
//             out        - signed sample
//             out_valid  - out carries a new sample this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module sin_gen_nco #(
  parameter int DATA_WIDTH = 16,
  parameter int PHASE_W    = 16,
  parameter int ADDR_W     = 8,
  parameter int AMP_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic                         cfg_sync,
  input  logic [PHASE_W-1:0]           cfg_freq,
  input  logic [PHASE_W-1:0]           cfg_phase,
  input  logic [AMP_W-1:0]             cfg_amp,
  output logic signed [DATA_WIDTH-1:0] out,
  output logic                         out_valid
);

  localparam int c_IW     = ADDR_W - 2;            // in-quadrant index width
  localparam int c_QM     = 2 ** c_IW;             // last quarter-table index
  localparam int c_PROD_W = DATA_WIDTH + AMP_W + 1;
  localparam int c_FX     = 30;                    // fixed-point fraction bits for table generation

  localparam logic [AMP_W-1:0] c_UNITY   = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [c_IW:0]    c_QM_ADDR = {1'b1, {c_IW{1'b0}}};
  localparam longint           c_HALF_PI_FX  = 64'sd1686629713;  // round(pi/2 * 2^30)
  localparam longint           c_FULL_SCALE  = (longint'(1) << (DATA_WIDTH-1)) - 1;

  localparam logic [0:0] c_ST_RUN  = 1'b0;
  localparam logic [0:0] c_ST_PEND = 1'b1;

  // Quarter-wave entry k: round(full_scale * sin(pi/2 * k/Qm)).
  // Evaluated with an integer Taylor series so it folds to constants at
  // elaboration without relying on real-valued math support.
  function automatic logic signed [DATA_WIDTH-1:0] lut_value(input int k);
    longint x;
    longint term;
    longint sum;
    longint full;
    x    = (c_HALF_PI_FX * longint'(k)) / longint'(c_QM);
    term = x;
    sum  = x;
    for (int n = 1; n <= 10; n++) begin
      term = (term * x) >>> c_FX;
      term = (term * x) >>> c_FX;
      term = -term / longint'((2*n) * (2*n + 1));
      sum  = sum + term;
    end
    full = (sum * c_FULL_SCALE + (longint'(1) << (c_FX-1))) >>> c_FX;
    return full[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] w_lut [0:c_QM];

  generate
    for (genvar k = 0; k <= c_QM; k++) begin : g_lut
      localparam logic signed [DATA_WIDTH-1:0] c_VAL = lut_value(k);
      assign w_lut[k] = c_VAL;
    end
  endgenerate

  // ---------------------------------------------------------------- config
  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_freq;
  logic [PHASE_W-1:0] r_phase;
  logic [AMP_W-1:0]   r_amp;
  logic [PHASE_W-1:0] r_sh_freq;
  logic [PHASE_W-1:0] r_sh_phase;
  logic [AMP_W-1:0]   r_sh_amp;
  logic [0:0]         r_state;

  logic [PHASE_W:0]   w_acc_sum;
  logic               w_wrap;
  logic               w_hs;
  logic               w_apply;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_freq};
  assign w_wrap    = w_acc_sum[PHASE_W];
  assign cfg_ready = (r_state == c_ST_RUN);
  assign w_hs      = cfg_valid & cfg_ready;
  // Only a wrap on an actual strobe marks a wave boundary.
  assign w_apply   = (r_state == c_ST_PEND) & clk_en & w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      r_freq     <= '0;
      r_phase    <= '0;
      r_amp      <= c_UNITY;
      r_sh_freq  <= '0;
      r_sh_phase <= '0;
      r_sh_amp   <= '0;
      r_state    <= c_ST_RUN;
    end else begin
      // Increment uses the old tuning word even on a handshake edge.
      if (clk_en) begin
        r_acc <= w_acc_sum[PHASE_W-1:0];
      end
      case (r_state)
        c_ST_RUN: begin
          if (w_hs) begin
            if (cfg_sync) begin
              r_sh_freq  <= cfg_freq;
              r_sh_phase <= cfg_phase;
              r_sh_amp   <= cfg_amp;
              r_state    <= c_ST_PEND;
            end else begin
              r_freq  <= cfg_freq;
              r_phase <= cfg_phase;
              r_amp   <= cfg_amp;
            end
          end
        end
        c_ST_PEND: begin
          if (w_apply) begin
            r_freq  <= r_sh_freq;
            r_phase <= r_sh_phase;
            r_amp   <= r_sh_amp;
            r_state <= c_ST_RUN;
          end
        end
        default: r_state <= c_ST_RUN;
      endcase
    end
  end

  // ------------------------------------------------------- stage 1: address
  logic [PHASE_W-1:0] w_phase_sum;
  logic [ADDR_W-1:0]  w_idx;
  logic [AMP_W-1:0]   w_amp_clamped;

  assign w_phase_sum   = r_acc + r_phase;
  assign w_idx         = w_phase_sum[PHASE_W-1 -: ADDR_W];
  assign w_amp_clamped = (r_amp > c_UNITY) ? c_UNITY : r_amp;

  logic               r_s1_valid;
  logic [1:0]         r_s1_quad;
  logic [c_IW-1:0]    r_s1_i;
  logic [AMP_W-1:0]   r_s1_amp;

  // ---------------------------------------------------- stage 2: LUT / fold
  logic [c_IW:0]                w_lut_addr;
  logic signed [DATA_WIDTH-1:0] w_lut_val;
  logic signed [DATA_WIDTH-1:0] w_fold;

  // Odd quadrants read the table backwards (Qm - i), which needs Qm+1 entries.
  assign w_lut_addr = r_s1_quad[0] ? (c_QM_ADDR - {1'b0, r_s1_i}) : {1'b0, r_s1_i};
  assign w_lut_val  = w_lut[w_lut_addr];
  assign w_fold     = r_s1_quad[1] ? -w_lut_val : w_lut_val;

  logic                         r_s2_valid;
  logic signed [DATA_WIDTH-1:0] r_s2_sample;
  logic [AMP_W-1:0]             r_s2_amp;

  // ------------------------------------------------------- stage 3: scale
  logic signed [c_PROD_W-1:0] w_prod;

  // Amplitude is zero-extended to keep it positive in the signed product;
  // with a <= unity the shifted result always fits DATA_WIDTH.
  assign w_prod = c_PROD_W'(r_s2_sample) * c_PROD_W'($signed({1'b0, r_s2_amp}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_quad   <= '0;
      r_s1_i      <= '0;
      r_s1_amp    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_sample <= '0;
      r_s2_amp    <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
    end else begin
      r_s1_valid  <= clk_en;
      r_s1_quad   <= w_idx[ADDR_W-1 -: 2];
      r_s1_i      <= w_idx[c_IW-1:0];
      r_s1_amp    <= w_amp_clamped;
      r_s2_valid  <= r_s1_valid;
      r_s2_sample <= w_fold;
      r_s2_amp    <= r_s1_amp;
      out_valid   <= r_s2_valid;
      if (r_s2_valid) begin
        out <= w_prod[AMP_W-1 +: DATA_WIDTH];  // arithmetic >>> (AMP_W-1)
      end
    end
  end

  // Truncated phase bits and the product's guard bits are intentionally dropped.
  logic w_unused;
  assign w_unused = ^{w_phase_sum[PHASE_W-ADDR_W-1:0], w_prod[AMP_W-2:0],
                      w_prod[c_PROD_W-1 -: 2]};

endmodule
`default_nettype wire

// File: tb/tb_sin_gen_nco.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sin_gen_nco
//  Purpose  : Self-checking bench for sin_gen_nco. A behavioural model
//             (full-wave sine via $sin, plain-arithmetic scaling, expected
//             sample queue with due times) is compared every clock against
//             the DUT, plus directed spot values from the waveform.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sin_gen_nco;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clk_en = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_sync = 1'b0;
  logic [15:0] cfg_freq = '0;
  logic [15:0] cfg_phase = '0;
  logic [15:0] cfg_amp = '0;
  logic        cfg_ready;
  logic        out_valid;
  logic signed [15:0] out;

  int total = 0;
  int bad = 0;

  // model state
  int     m_acc, m_freq, m_phase, m_amp;
  int     s_freq, s_phase, s_amp;
  bit     m_pend;
  int     exp_out;
  int     q_val[$];
  longint q_due[$];
  longint edge_n = 0;
  int     got[$];
  int     n;

  sin_gen_nco #(
    .DATA_WIDTH(16), .PHASE_W(16), .ADDR_W(8), .AMP_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_sync  (cfg_sync),
    .cfg_freq  (cfg_freq),
    .cfg_phase (cfg_phase),
    .cfg_amp   (cfg_amp),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Ideal sine at the truncated 256-point phase, rounded half away from zero.
  function automatic int ref_sine(input int phase);
    int  idx;
    real v;
    idx = (phase % 65536) / 256;
    v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 256.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int ref_scale(input int s, input int amp);
    longint a, p;
    a = (amp > 32768) ? 32768 : amp;
    p = longint'(s) * a;
    if (p >= 0) return int'(p / 32768);
    else        return -int'((-p + 32767) / 32768);   // floor
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_freq = 0; m_phase = 0; m_amp = 32768;
    s_freq = 0; s_phase = 0; s_amp = 0;
    m_pend = 0;
    exp_out = 0;
    q_val.delete();
    q_due.delete();
  endtask

  // One clock: advance the model with the inputs seen at the edge, then
  // compare outputs 1 time unit later.
  task automatic tick();
    bit wrap;
    bit exp_v;
    @(posedge clk);
    edge_n++;
    wrap = 0;
    if (!rst) begin
      model_reset();
    end else begin
      if (clk_en) begin
        q_val.push_back(ref_scale(ref_sine(m_acc + m_phase), m_amp));
        q_due.push_back(edge_n + 2);
        wrap  = (m_acc + m_freq) > 65535;
        m_acc = (m_acc + m_freq) % 65536;
      end
      if (m_pend) begin
        if (clk_en && wrap) begin
          m_freq = s_freq; m_phase = s_phase; m_amp = s_amp; m_pend = 0;
        end
      end else if (cfg_valid) begin
        if (cfg_sync) begin
          s_freq = int'(cfg_freq); s_phase = int'(cfg_phase); s_amp = int'(cfg_amp);
          m_pend = 1;
        end else begin
          m_freq = int'(cfg_freq); m_phase = int'(cfg_phase); m_amp = int'(cfg_amp);
        end
      end
    end
    #1;
    exp_v = 0;
    if (q_due.size() > 0 && q_due[0] == edge_n) begin
      exp_v   = 1;
      exp_out = q_val[0];
      void'(q_val.pop_front());
      void'(q_due.pop_front());
    end
    check("out_valid", out_valid, exp_v);
    check("out", out, exp_out);
    check("cfg_ready", cfg_ready, !m_pend);
    if (out_valid === 1'b1) got.push_back(int'(out));
  endtask

  task automatic cfg(input logic [15:0] f, input logic [15:0] ph,
                     input logic [15:0] a, input logic s, output int ticks);
    logic accepted;
    cfg_valid = 1; cfg_freq = f; cfg_phase = ph; cfg_amp = a; cfg_sync = s;
    ticks = 0;
    accepted = 0;
    while (!accepted && ticks < 300) begin
      accepted = cfg_ready;
      tick();
      ticks++;
    end
    cfg_valid = 0;
    check("cfg_accept", accepted, 1);
  endtask

  task automatic drain();
    clk_en = 0;
    repeat (3) tick();
  endtask

  task automatic async_reset_check();
    rst = 0;
    #2;
    model_reset();
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cfg_ready", cfg_ready, 1);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1;
    repeat (2) tick();

    // no configuration: freq 0, phase 0 -> all-zero samples
    got.delete();
    clk_en = 1;
    repeat (8) tick();
    drain();
    check("idle_count", got.size(), 8);
    check("idle_s0", got[0], 0);
    check("idle_s7", got[7], 0);

    // frequency 0x0400, unity gain, strobe every cycle
    cfg(16'h0400, 16'h0000, 16'h8000, 1'b0, n);
    got.delete();
    clk_en = 1;
    repeat (64) tick();
    drain();
    check("f_count", got.size(), 64);
    check("f_s0", got[0], 0);
    check("f_s8", got[8], 23170);
    check("f_s16", got[16], 32767);
    check("f_s32", got[32], 0);
    check("f_s48", got[48], -32767);

    // same with a strobe every second cycle
    got.delete();
    repeat (64) begin
      clk_en = 1; tick();
      clk_en = 0; tick();
    end
    drain();
    check("f2_count", got.size(), 64);
    check("f2_s16", got[16], 32767);
    check("f2_s48", got[48], -32767);

    // half amplitude (floor on the negative peak), then clamp above unity
    cfg(16'h0400, 16'h0000, 16'h4000, 1'b0, n);
    got.delete();
    clk_en = 1;
    repeat (64) tick();
    drain();
    check("a_half_s16", got[16], 16383);
    check("a_half_s48", got[48], -16384);
    cfg(16'h0400, 16'h0000, 16'hFFFF, 1'b0, n);
    got.delete();
    clk_en = 1;
    repeat (64) tick();
    drain();
    check("a_clamp_s16", got[16], 32767);
    check("a_clamp_s48", got[48], -32767);

    // phase offset only
    cfg(16'h0000, 16'h4000, 16'h8000, 1'b0, n);
    got.delete();
    clk_en = 1;
    repeat (8) tick();
    drain();
    check("ph_4000_s0", got[0], 32767);
    check("ph_4000_s7", got[7], 32767);
    cfg(16'h0000, 16'hC000, 16'h8000, 1'b0, n);
    got.delete();
    clk_en = 1;
    repeat (8) tick();
    drain();
    check("ph_C000_s0", got[0], -32767);
    check("ph_C000_s7", got[7], -32767);

    // phase-continuous frequency switch at the wave wrap
    cfg(16'h0400, 16'h0000, 16'h8000, 1'b0, n);
    got.delete();
    clk_en = 1;
    repeat (10) tick();
    cfg(16'h0800, 16'h0000, 16'h8000, 1'b1, n);
    check("sync_ready_low", cfg_ready, 0);
    n = 0;
    while (cfg_ready === 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("sync_wait", n, 53);
    check("sync_ready_back", cfg_ready, 1);
    repeat (10) tick();
    drain();
    check("sync_count", got.size(), 74);
    check("sync_s63", got[63], -3212);
    check("sync_s64", got[64], 0);
    check("sync_s65", got[65], 6393);
    check("sync_s66", got[66], 12539);

    // cfg_valid held through PENDING: second word waits for cfg_ready
    clk_en = 1;
    cfg(16'h1000, 16'h0000, 16'h8000, 1'b1, n);
    cfg(16'h0400, 16'h0000, 16'h4000, 1'b0, n);
    check("collide_ticks", n, 22);
    repeat (4) tick();
    check("collide_ready", cfg_ready, 1);

    // async reset while PENDING
    cfg(16'h2000, 16'h0000, 16'h8000, 1'b1, n);
    repeat (2) tick();
    async_reset_check();
    repeat (3) tick();
    rst = 1;
    got.delete();
    repeat (10) tick();
    drain();
    check("post_rst_count", got.size(), 10);
    check("post_rst_s0", got[0], 0);
    check("post_rst_s9", got[9], 0);

    // freq 0 never wraps: a synced config stays pending until reset
    cfg(16'h0400, 16'h0000, 16'h8000, 1'b1, n);
    clk_en = 1;
    repeat (100) tick();
    check("stuck_pending", cfg_ready, 0);
    async_reset_check();
    tick();
    rst = 1;
    repeat (2) tick();

    // randomized traffic against the model
    cfg(16'h0321, 16'h0000, 16'h8000, 1'b0, n);
    repeat (600) begin
      clk_en    = ($urandom_range(0, 3) != 0);
      cfg_valid = ($urandom_range(0, 15) == 0);
      cfg_sync  = 1'($urandom_range(0, 1));
      cfg_freq  = 16'($urandom_range(1, 65535));
      cfg_phase = 16'($urandom);
      cfg_amp   = 16'($urandom);
      tick();
    end
    cfg_valid = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sin_gen_nco.md
Name: sin_gen_nco

Overview:
- Parametrised successor to the fixed 50-point sine generator.
- Numerically controlled oscillator with these features:
  - phase accumulator with a run-time frequency tuning word
  - phase offset
  - amplitude scaling
  - quarter-wave LUT with symmetry folding
- Sits upstream of the delta-sigma modulator and produces one signed sample per clk_en strobe.
- Configuration is loaded through a valid/ready handshake, applied either immediately or phase-continuously at the next wave wrap.

Parameters:
- DATA_WIDTH, 16: output sample width, signed two's complement.
- PHASE_W, 16: phase accumulator, tuning word and phase offset width.
- ADDR_W, 8: full-wave LUT index bits; quarter table holds Q = 2^(ADDR_W-2) + 1 entries.
- AMP_W, 16: amplitude word width; unity gain = 2^(AMP_W-1).

Ports:
- clk  in  1: system clock.
- rst  in  1: reset, asynchronous, active-low.
- clk_en  in  1: sample strobe; one sample is produced per cycle where it is high.
- cfg_valid  in  1: configuration word valid.
- cfg_ready  out  1: block can accept configuration.
- cfg_sync  in  1: 1 = apply at next accumulator wrap; 0 = apply immediately.
- cfg_freq  in  PHASE_W: frequency tuning word.
- cfg_phase  in  PHASE_W: phase offset.
- cfg_amp  in  AMP_W: amplitude, unsigned.
- out  out  DATA_WIDTH: signed sample.
- out_valid  out  1: out carries a new sample this cycle.

Behaviour:
- Reset (rst low, async), all of these take effect immediately:
  - acc=0, freq_reg=0, phase_reg=0, amp_reg=2^(AMP_W-1)
  - out=0, out_valid=0, pipeline valids=0
  - FSM=RUN, cfg_ready=1
  - any pending shadow config is discarded.
- Accumulator:
  - On a clk_en cycle: acc <= acc + freq_reg, modulo 2^PHASE_W.
  - The sample for that strobe uses the pre-increment acc.
  - wrap = carry out of that addition.
- Phase to address:
  - p = (acc + phase_reg) mod 2^PHASE_W.
  - idx = p[PHASE_W-1 -: ADDR_W], truncated with no rounding.
  - quadrant = idx[ADDR_W-1:ADDR_W-2]; i = idx[ADDR_W-3:0]; Qm = 2^(ADDR_W-2).
- LUT: lut[k] = round((2^(DATA_WIDTH-1)-1) * sin(pi/2 * k/Qm)) for k = 0..Qm, generated at elaboration.
- Quadrant folding:
  - q0: +lut[i]
  - q1: +lut[Qm-i]
  - q2: -lut[i]
  - q3: -lut[Qm-i]
- Scaling:
  - a = min(amp_reg, 2^(AMP_W-1)); values above unity clamp to unity.
  - out = (s * a) >>> (AMP_W-1), arithmetic shift (floor).
  - The full-width product must not overflow.
- Pipeline:
  - Three register stages: address, LUT/fold, scale.
  - The pipeline advances every clk.
  - out_valid is high exactly 3 clk after a clk_en-high cycle, for 1 cycle.
  - out holds its value between valid cycles.
- Config FSM:
  - RUN: cfg_ready=1. On cfg_valid && cfg_ready:
    - cfg_sync=0: freq_reg, phase_reg and amp_reg are loaded at that edge; the next clk_en uses the new values.
    - cfg_sync=1: the config is latched into shadow registers and the FSM goes to PENDING.
  - PENDING: cfg_ready=0.
    - On the first clk_en cycle with wrap=1, the shadow is copied to the live registers at that edge; the next strobe uses the new values; FSM returns to RUN.
    - If freq_reg=0, no wrap ever occurs and the FSM remains PENDING until reset.
  - A handshake on the same cycle as a clk_en: the sample of that strobe uses the old values.
- Registers change only on a handshake or a sync-apply; the cfg_* inputs are ignored otherwise.

Test Plan (defaults, clk_en every cycle unless stated):
1. Reset:
   - Stimulus: assert rst=0 mid-run, including while in PENDING.
   - Response: out=0, out_valid=0 and cfg_ready=1 immediately.
   - After release with no config: samples are all 0 (freq 0, phase 0).
2. Frequency:
   - Stimulus: load cfg_freq=0x0400, cfg_amp=0x8000, cfg_sync=0.
   - Response: period is 64 samples; samples 0, 16, 32, 48 = 0, 32767, 0, -32767.
   - out_valid follows each clk_en by exactly 3 clk.
   - Repeat with clk_en on every 2nd cycle: same sequence, out_valid on alternate cycles.
3. Amplitude:
   - cfg_amp=0x4000: sample 16 = 16383 and sample 48 = -16384 (floor).
   - cfg_amp=0xFFFF: clamps to unity, peak = 32767.
4. Phase offset:
   - Stimulus: cfg_freq=0, cfg_phase=0x4000.
   - Response: constant 32767.
   - cfg_phase=0xC000: constant -32767.
5. Sync update:
   - Stimulus: running at freq 0x0400; at sample 10 handshake cfg_freq=0x0800 with cfg_sync=1.
   - Response: cfg_ready=0; step stays 0x0400 through the wrap strobe (acc 0xFC00).
   - The next sample uses acc 0x0000, then step 0x0800; cfg_ready returns to 1.
   - No output discontinuity at the switch.
6. Handshake collision:
   - Stimulus: cfg_valid is held during PENDING.
   - Response: no acceptance; the second config is accepted on the first cycle cfg_ready=1.
